// File: rtl/ieeedrv_pkg.sv
// Shared types for the IEEE drive SD arbiter.
// Sequencer states and default acknowledge watchdog limit.
package ieeedrv_pkg;

  typedef enum logic [1:0] {
    SDA_IDLE = 2'd0,
    SDA_REQ  = 2'd1,
    SDA_XFER = 2'd2,
    SDA_DONE = 2'd3
  } sda_state_t;

  localparam logic [23:0] SDA_ACK_TIMEOUT = 24'hFFFFFF;

endpackage

// File: rtl/ieeedrv_rr_pick.sv
// Round-robin picker: first set bit of pend at or after ptr,
// wrapping modulo N. Purely combinational.
module ieeedrv_rr_pick
  import ieeedrv_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  pend,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] idx,
  output logic          valid
);

  logic [2*N-1:0] rot;
  int             sum;

  always_comb begin
    rot   = {pend, pend} >> ptr;
    idx   = '0;
    valid = 1'b0;
    sum   = 0;
    for (int k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        idx   = GW'(sum);
      end
    end
  end

endmodule

// File: rtl/ieeedrv_sd_arb.sv
// Shares the HPS SD block port between IEEE subdrives:
// latches load/save requests, grants round-robin, runs the handshake.
module ieeedrv_sd_arb
  import ieeedrv_pkg::*;
#(
  parameter int          SUBDRV      = 2,
  parameter logic [23:0] ACK_TIMEOUT = SDA_ACK_TIMEOUT,
  localparam int         NS          = SUBDRV - 1,
  localparam int         GW          = (SUBDRV > 1) ? $clog2(SUBDRV) : 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [NS:0]         req_rd,
  input  logic [NS:0]         req_wr,
  input  logic [NS:0][31:0]   req_lba,
  input  logic [NS:0][5:0]    req_cnt,
  input  logic [NS:0]         img_mounted,
  output logic [NS:0]         busy,
  output logic [NS:0]         done,
  output logic [NS:0]         timeout,
  output logic [GW-1:0]       grant,
  output logic                active,
  output logic [31:0]         sd_lba,
  output logic [5:0]          sd_blk_cnt,
  output logic [NS:0]         sd_rd,
  output logic [NS:0]         sd_wr,
  input  logic [NS:0]         sd_ack
);

  sda_state_t    state;
  logic [NS:0]   pend_rd;
  logic [NS:0]   pend_wr;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick_idx;
  logic          pick_vld;
  logic          kind_wr;
  logic          to_flag;
  logic [23:0]   wd;
  logic [23:0]   wd_inc;

  logic [NS:0]   gsel;
  logic [NS:0]   psel;
  logic          pick_wr;
  logic          ack_g;
  logic          start;
  logic [NS:0]   act_rd;
  logic [NS:0]   act_wr;
  logic [NS:0]   clr_rd;
  logic [NS:0]   clr_wr;

  ieeedrv_rr_pick #(
    .N  (SUBDRV),
    .GW (GW)
  ) u_pick (
    .pend  (pend_rd | pend_wr),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign gsel    = (NS+1)'(1) << grant;
  assign psel    = (NS+1)'(1) << pick_idx;
  assign pick_wr = |(pend_wr & psel);
  assign ack_g   = |(sd_ack & gsel);
  assign start   = (state == SDA_IDLE) && pick_vld;
  assign active  = (state == SDA_REQ) || (state == SDA_XFER);
  assign wd_inc  = wd + 24'd1;

  assign act_rd  = (active && !kind_wr) ? gsel : '0;
  assign act_wr  = (active &&  kind_wr) ? gsel : '0;

  // A mount only discards work that has not started yet.
  assign clr_rd  = ((start && !pick_wr) ? psel : '0)
                 | (img_mounted & ~act_rd);
  assign clr_wr  = ((start &&  pick_wr) ? psel : '0)
                 | (img_mounted & ~act_wr);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_rd <= '0;
      pend_wr <= '0;
    end else begin
      pend_rd <= (pend_rd & ~clr_rd) | req_rd;
      pend_wr <= (pend_wr & ~clr_wr) | req_wr;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= SDA_IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      kind_wr    <= 1'b0;
      to_flag    <= 1'b0;
      wd         <= '0;
      sd_lba     <= '0;
      sd_blk_cnt <= '0;
    end else begin
      unique case (state)
        SDA_IDLE: begin
          if (pick_vld) begin
            state      <= SDA_REQ;
            grant      <= pick_idx;
            kind_wr    <= pick_wr;
            sd_lba     <= req_lba[pick_idx];
            sd_blk_cnt <= req_cnt[pick_idx];
            wd         <= '0;
            to_flag    <= 1'b0;
          end
        end
        SDA_REQ: begin
          if (ack_g) begin
            state <= SDA_XFER;
          end else if (wd_inc == ACK_TIMEOUT) begin
            state   <= SDA_DONE;
            to_flag <= 1'b1;
          end else begin
            wd <= wd_inc;
          end
        end
        SDA_XFER: begin
          if (!ack_g) state <= SDA_DONE;
        end
        SDA_DONE: begin
          state  <= SDA_IDLE;
          rr_ptr <= (grant == GW'(NS)) ? '0 : grant + GW'(1);
        end
        default: state <= SDA_IDLE;
      endcase
    end
  end

  assign sd_rd   = act_rd & {(NS+1){state == SDA_REQ}};
  assign sd_wr   = act_wr & {(NS+1){state == SDA_REQ}};
  assign done    = (state == SDA_DONE) ? gsel : '0;
  assign timeout = (state == SDA_DONE && to_flag) ? gsel : '0;
  assign busy    = pend_rd | pend_wr | (active ? gsel : '0);

endmodule
